// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

   localparam int CNT_W  = 4;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: synchronous write plus a read register.
// The read register is loaded by the access strobe and holds zero otherwise.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              access_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
   logic [WORD_W-1:0] rdata_q;

   // NOTE: storage has no reset branch so it maps onto plain RAM; contents are undefined after power-up.
   always_ff @(posedge clk_i) begin
      if (access_i && we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   // Zero except on the cycle after a read access, so writes and idle cycles show 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (access_i && !we_i) begin
         rdata_q <= mem_q[idx_i];
      end else begin
         rdata_q <= '0;
      end
   end

   assign rdata_o = rdata_q;

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// Request/acknowledge data-memory target with LATENCY wait states and a one-cycle ack.
// Optional DMEM_MISALIGN_CHECK_EN flags accesses with addr[1:0] != 0 and suppresses their write.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [WORD_W-1:0] addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic              ack_o,
   output logic [WORD_W-1:0] rdata_o,
   output logic              err_o,
   output logic              busy_o
);

   localparam int               IDX_W = $clog2(DEPTH_WORDS);
   localparam int               AW    = IDX_W + 2;
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [AW-1:0]     addr_q, addr_d;
   logic              we_q, we_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              ack_q, err_q;
   logic              accept, enter_resp, misalign, access;
   logic              unused_addr;

   // With LATENCY=0 the access fires on the accept edge, so it must see the live inputs.
   always_comb begin
      accept     = (state_q == IDLE) && req_i;
      addr_d     = accept ? addr_i[AW-1:0] : addr_q;
      we_d       = accept ? we_i : we_q;
      wdata_d    = accept ? wdata_i : wdata_q;
      enter_resp = (accept && (LATENCY == 0)) ||
                   ((state_q == WAIT) && (cnt_q <= CNT_W'(1)));
`ifdef DMEM_MISALIGN_CHECK_EN
      misalign   = (addr_d[1:0] != 2'b00);
`else
      misalign   = 1'b0;
`endif
      access     = enter_resp && !misalign;
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   assign unused_addr = ^addr_i[WORD_W-1:AW];
`else
   assign unused_addr = ^{addr_i[WORD_W-1:AW], addr_d[1:0]};
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ack_q <= enter_resp;
         err_q <= enter_resp && misalign;
         unique case (state_q)
            IDLE: begin
               if (req_i) begin
                  addr_q  <= addr_d;
                  we_q    <= we_d;
                  wdata_q <= wdata_d;
                  cnt_q   <= LAT_C;
                  state_q <= (LATENCY == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q <= CNT_W'(1)) begin
                  state_q <= RESP;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .access_i (access),
      .we_i     (we_d),
      .idx_i    (addr_d[AW-1:2]),
      .wdata_i  (wdata_d),
      .rdata_o  (rdata_o)
   );

   assign ack_o  = ack_q;
   assign err_o  = err_q;
   assign busy_o = (state_q != IDLE);

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with LATENCY 2, 0 and 4.
// Misalignment expectations follow DMEM_MISALIGN_CHECK_EN.
module tb_dmem_responder;

   logic        clk;
   logic        rst_n;
   logic        req   [3];
   logic        we    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic        ack   [3];
   logic [31:0] rdata [3];
   logic        err   [3];
   logic        busy  [3];

   int checks   = 0;
   int failures = 0;

   localparam int D_L2 = 0;
   localparam int D_L0 = 1;
   localparam int D_L4 = 2;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_l2 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
      .wdata_i(wdata[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0]), .busy_o(busy[0]));

   dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) u_l0 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
      .wdata_i(wdata[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1]), .busy_o(busy[1]));

   dmem_responder #(.DEPTH_WORDS(64), .LATENCY(4)) u_l4 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]),
      .wdata_i(wdata[2]), .ack_o(ack[2]), .rdata_o(rdata[2]), .err_o(err[2]), .busy_o(busy[2]));

   // One transaction: starts at a falling edge, returns the cycle count to ack (-1 on timeout).
   task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      output int cyc, output logic [31:0] rd, output logic e,
                      output logic busy1, output logic ack_nx, output logic [31:0] rd_nx);
      req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
      cyc = -1; busy1 = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) busy1 = busy[d];
         if (ack[d] === 1'b1) begin
            cyc = i;
            break;
         end
      end
      rd = rdata[d]; e = err[d];
      req[d] = 1'b0;
      @(negedge clk);
      ack_nx = ack[d]; rd_nx = rdata[d];
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({ack[d], err[d], busy[d]} !== 3'b000 || rdata[d] !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs inst=%0d ack=%b err=%b busy=%b rdata=%h expected all 0",
                     d, ack[d], err[d], busy[d], rdata[d]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (busy[d] !== 1'b0 || ack[d] !== 1'b0) begin
            failures++;
            $display("FAIL reset_release inst=%0d busy=%b ack=%b expected 0 0", d, busy[d], ack[d]);
         end
      end
   endtask

   task automatic test_write_read();
      int cyc; logic [31:0] rd, rd_nx; logic e, b1, a_nx;
      txn(D_L2, 1'b1, 32'h10, 32'hDEADBEEF, cyc, rd, e, b1, a_nx, rd_nx);
      checks++;
      if (cyc !== 3 || rd !== 32'h0 || e !== 1'b0 || b1 !== 1'b1) begin
         failures++;
         $display("FAIL wr_write cyc=%0d rdata=%h err=%b busy=%b expected 3 0 0 1", cyc, rd, e, b1);
      end
      checks++;
      if (a_nx !== 1'b0) begin
         failures++;
         $display("FAIL wr_ack_width ack_after=%b expected 0", a_nx);
      end
      txn(D_L2, 1'b0, 32'h10, 32'h0, cyc, rd, e, b1, a_nx, rd_nx);
      checks++;
      if (cyc !== 3 || rd !== 32'hDEADBEEF || e !== 1'b0) begin
         failures++;
         $display("FAIL wr_read cyc=%0d rdata=%h err=%b expected 3 deadbeef 0", cyc, rd, e);
      end
      checks++;
      if (a_nx !== 1'b0 || rd_nx !== 32'h0) begin
         failures++;
         $display("FAIL wr_rdata_clear ack=%b rdata=%h expected 0 0", a_nx, rd_nx);
      end
   endtask

   task automatic test_wrap();
      int cyc; logic [31:0] rd, rd_nx; logic e, b1, a_nx;
      txn(D_L2, 1'b1, 32'h100, 32'hA5A5A5A5, cyc, rd, e, b1, a_nx, rd_nx);
      txn(D_L2, 1'b0, 32'h0, 32'h0, cyc, rd, e, b1, a_nx, rd_nx);
      checks++;
      if (cyc !== 3 || rd !== 32'hA5A5A5A5) begin
         failures++;
         $display("FAIL wrap_read cyc=%0d rdata=%h expected 3 a5a5a5a5", cyc, rd);
      end
   endtask

   task automatic test_misaligned();
      int cyc; logic [31:0] rd, rd_nx; logic e, b1, a_nx;
      logic        exp_err;
      logic [31:0] exp_word;
`ifdef DMEM_MISALIGN_CHECK_EN
      exp_err = 1'b1; exp_word = 32'hDEADBEEF;
`else
      exp_err = 1'b0; exp_word = 32'h12345678;
`endif
      txn(D_L2, 1'b1, 32'h13, 32'h12345678, cyc, rd, e, b1, a_nx, rd_nx);
      checks++;
      if (cyc !== 3 || e !== exp_err || rd !== 32'h0) begin
         failures++;
         $display("FAIL misalign_write cyc=%0d err=%b rdata=%h expected 3 %b 0", cyc, e, rd, exp_err);
      end
      checks++;
      if (a_nx !== 1'b0) begin
         failures++;
         $display("FAIL misalign_err_clear ack=%b expected 0", a_nx);
      end
      txn(D_L2, 1'b0, 32'h10, 32'h0, cyc, rd, e, b1, a_nx, rd_nx);
      checks++;
      if (rd !== exp_word || e !== 1'b0) begin
         failures++;
         $display("FAIL misalign_readback rdata=%h err=%b expected %h 0", rd, e, exp_word);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, gap; logic [31:0] rd, rd_nx, first; logic e, b1, a_nx;
      txn(D_L0, 1'b1, 32'h0, 32'h11, cyc, rd, e, b1, a_nx, rd_nx);
      checks++;
      if (cyc !== 1 || rd !== 32'h0) begin
         failures++;
         $display("FAIL b2b_write_latency cyc=%0d rdata=%h expected 1 0", cyc, rd);
      end
      txn(D_L0, 1'b1, 32'h4, 32'h22, cyc, rd, e, b1, a_nx, rd_nx);
      req[D_L0] = 1'b1; we[D_L0] = 1'b0; addr[D_L0] = 32'h0;
      cyc = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (ack[D_L0] === 1'b1) begin cyc = i; break; end
      end
      first = rdata[D_L0];
      addr[D_L0] = 32'h4;
      gap = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (ack[D_L0] === 1'b1) begin gap = i; break; end
      end
      rd = rdata[D_L0];
      req[D_L0] = 1'b0;
      @(negedge clk);
      checks++;
      if (cyc !== 1 || first !== 32'h11) begin
         failures++;
         $display("FAIL b2b_first cyc=%0d rdata=%h expected 1 00000011", cyc, first);
      end
      checks++;
      if (gap !== 2 || rd !== 32'h22) begin
         failures++;
         $display("FAIL b2b_second gap=%0d rdata=%h expected 2 00000022", gap, rd);
      end
   endtask

   task automatic test_reset_mid_wait();
      int cyc, acks; logic [31:0] rd, rd_nx; logic e, b1, a_nx;
      txn(D_L4, 1'b1, 32'h8, 32'h0BADBEEF, cyc, rd, e, b1, a_nx, rd_nx);
      checks++;
      if (cyc !== 5) begin
         failures++;
         $display("FAIL rmw_prior_latency cyc=%0d expected 5", cyc);
      end
      req[D_L4] = 1'b1; we[D_L4] = 1'b1; addr[D_L4] = 32'h8; wdata[D_L4] = 32'hCAFEF00D;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      req[D_L4] = 1'b0;
      #1;
      checks++;
      if ({ack[D_L4], err[D_L4], busy[D_L4]} !== 3'b000 || rdata[D_L4] !== 32'h0) begin
         failures++;
         $display("FAIL rmw_in_reset ack=%b err=%b busy=%b rdata=%h expected all 0",
                  ack[D_L4], err[D_L4], busy[D_L4], rdata[D_L4]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack[D_L4] !== 1'b0) acks++;
         if (i == 0) begin
            checks++;
            if (busy[D_L4] !== 1'b0) begin
               failures++;
               $display("FAIL rmw_busy_after_release busy=%b expected 0", busy[D_L4]);
            end
         end
      end
      checks++;
      if (acks != 0) begin
         failures++;
         $display("FAIL rmw_no_ack acks=%0d expected 0", acks);
      end
      txn(D_L4, 1'b0, 32'h8, 32'h0, cyc, rd, e, b1, a_nx, rd_nx);
      checks++;
      if (cyc !== 5 || rd !== 32'h0BADBEEF) begin
         failures++;
         $display("FAIL rmw_readback cyc=%0d rdata=%h expected 5 0badbeef", cyc, rd);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wrap();
      test_misaligned();
      test_back_to_back();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dmem_responder

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the target end of the datapath's load/store interface, replacing the zero-wait DataMem with a request/acknowledge handshake and a programmable wait-state count. It accepts one word transaction at a time, holds it for LATENCY cycles, performs the read or write on word-addressed storage, and returns a one-cycle acknowledge with read data. It sits between the datapath's ALU address/rt-data outputs and the MemToReg mux, and is used by the upcoming multi-cycle/stalling core.

## Interface
- DEPTH_WORDS, 64: storage size in 32-bit words; power of two, at least 2.
- LATENCY, 2: wait cycles between acceptance and response; 0 to 15.
- clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- req  input  1  transaction request; must be held with addr/we/wdata stable until ack.
- we  input  1  1 = write, 0 = read.
- addr  input  32  byte address.
- wdata  input  32  write data.
- ack  output  1  one-cycle response strobe.
- rdata  output  32  read data, valid while ack=1; 0 for writes and errors.
- err  output  1  misaligned access flag, valid while ack=1.
- busy  output  1  1 whenever state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on an edge with req=1, latch addr, we, wdata; load the wait counter with LATENCY; go to WAIT, or straight to RESP if LATENCY=0.
- WAIT: decrement the counter each edge; on the edge where it reaches 0, go to RESP.
- Access happens on the edge entering RESP: write stores wdata; read loads the rdata register.
- RESP: ack=1 for exactly one cycle, then IDLE unconditionally.
- Word index = latched addr[log2(DEPTH_WORDS)+1:2]; higher bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Back-to-back: if req is still 1 in the IDLE cycle after RESP, a new transaction is accepted. The initiator must drop req in the cycle after ack unless it intends a new access.
- req is ignored outside IDLE; input changes during WAIT have no effect.
- Storage is not reset; contents are undefined after power-up.

## Timing
- Reset values (asynchronous): state=IDLE, ack=0, err=0, rdata=0, busy=0, counter=0.
- Accept at edge k leads to ack=1 during cycle k+LATENCY+1. Total occupancy is LATENCY+2 cycles per transaction, including the IDLE acceptance cycle.
- Every output is registered; nothing combinational runs from inputs to outputs.
- Reset during WAIT: the transaction is aborted, no write occurs, and no ack is issued. Reset during RESP: ack drops immediately. A write already committed on the RESP-entry edge stays in storage.
- rdata and err return to 0 in the cycle after RESP.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined: if the latched addr[1:0] is not 0, the RESP cycle shows err=1 and rdata=0, and no write is performed. The timing is identical to an aligned access.
- Not defined: addr[1:0] is ignored, err is tied to 0, and every access is treated as aligned.

## Structure
- Shared package dmem_pkg: the state enum (IDLE, WAIT, RESP), the counter width constant (4 bits), and the word width constant (32).
- Sub-module dmem_array: DEPTH_WORDS×32 storage with synchronous write and registered read, driven by a single access strobe. The FSM, counter, latches and error logic stay in dmem_responder.

## Test plan
- Reset: hold Reset=0 mid-run, then check ack=0, err=0, rdata=0, busy=0. Release and confirm IDLE, with busy=0 at the next edge.
- Write then read, LATENCY=2: write 0xDEADBEEF to 0x10 and check ack after 3 cycles with rdata=0. Read 0x10 and check ack in cycle k+3 with rdata=0xDEADBEEF.
- Back-to-back, LATENCY=0: hold req high across two reads of 0x0 and 0x4, with prior writes 0x11 and 0x22. Expect acks 2 cycles apart, returning 0x11 then 0x22.
- Wrap-around, DEPTH_WORDS=64: write 0xA5A5A5A5 to 0x100, then read 0x0 and expect 0xA5A5A5A5.
- Misaligned, macro defined: write 0x12345678 to 0x13 and expect err=1 on ack. A following read of 0x10 returns its old value, proving no write occurred. With the macro undefined, the same write lands at word 4 and err=0.
- Reset mid-WAIT, LATENCY=4: issue a write of 0xCAFEF00D to 0x8 and pulse Reset=0 on cycle 2. Expect no ack; a later read of 0x8 returns its prior value.
